// File: rtl/psum_accumulator.sv
// Partial-sum accumulator behind conv2d: sums one output channel across all input
// channels, then applies bias, saturation and optional ReLU on the last pass.
module psum_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int MAX_PIX    = 4096,
    parameter int PIX_AW     = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [8:0]            i_max_width,
    input  logic [8:0]            i_max_height,
    input  logic [9:0]            i_max_ci,
    input  logic [DATA_WIDTH-1:0] i_bias,
    input  logic                  i_relu,
    input  logic [DATA_WIDTH-1:0] i_d,
    input  logic                  i_valid,
    input  logic                  i_ch_done,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_ch_done,
    output logic                  o_done,
    output logic                  o_busy,
    output logic                  o_err
);
    localparam int NW = 19;
    localparam int SW = ACC_WIDTH + 2;
    localparam logic signed [SW-1:0] SMAX = SW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SMIN = -SMAX - SW'(1);

    typedef enum logic {IDLE, ACCUM} state_e;

    state_e                  state_q, state_d;
    logic [NW-1:0]           npix_q, npix_d;
    logic [9:0]              ci_last_q, ci_last_d;
    logic [DATA_WIDTH-1:0]   bias_q, bias_d;
    logic                    relu_q, relu_d;
    logic [9:0]              c_ch_q, c_ch_d;
    logic [PIX_AW-1:0]       c_pix_q, c_pix_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ch_done_q, ch_done_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic signed [ACC_WIDTH-1:0] acc_q [MAX_PIX];

    logic                        in_acc, pix_full, pix_acc, ch_end, last_ch;
    logic [NW-1:0]               pix_ext, cnt_after;
    logic signed [ACC_WIDTH-1:0] d_ext, acc_rd, base, acc_wr;
    logic signed [SW-1:0]        sum, res;

    always_comb begin
        in_acc    = (state_q == ACCUM);
        pix_ext   = NW'(c_pix_q);
        pix_full  = (pix_ext == npix_q);
        pix_acc   = in_acc && i_valid && !pix_full;
        ch_end    = in_acc && i_ch_done;
        last_ch   = (c_ch_q == ci_last_q);
        cnt_after = pix_ext + NW'(pix_acc);

        d_ext  = ACC_WIDTH'(signed'(i_d));
        acc_rd = acc_q[c_pix_q];
        // Channel 0 overwrites, so stale contents from a prior filter never leak in.
        base   = (c_ch_q == '0) ? '0 : acc_rd;
        acc_wr = base + d_ext;

        sum = SW'(base) + SW'(d_ext) + SW'(signed'(bias_q));
        if (sum > SMAX)      res = SMAX;
        else if (sum < SMIN) res = SMIN;
        else                 res = sum;
        if (relu_q && res < 0) res = '0;
    end

    always_comb begin
        state_d   = state_q;
        npix_d    = npix_q;
        ci_last_d = ci_last_q;
        bias_d    = bias_q;
        relu_d    = relu_q;
        c_ch_d    = c_ch_q;
        c_pix_d   = c_pix_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ch_done_d = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d   = ACCUM;
                    npix_d    = NW'(i_max_width) * NW'(i_max_height);
                    ci_last_d = (i_max_ci == '0) ? '0 : i_max_ci - 10'd1;
                    bias_d    = i_bias;
                    relu_d    = i_relu;
                    c_ch_d    = '0;
                    c_pix_d   = '0;
                    err_d     = 1'b0;
                end
            end
            ACCUM: begin
                if (i_valid && pix_full) err_d = 1'b1;
                if (pix_acc) begin
                    c_pix_d = c_pix_q + PIX_AW'(1);
                    if (last_ch) begin
                        valid_d = 1'b1;
                        data_d  = DATA_WIDTH'(res);
                    end
                end
                if (ch_end) begin
                    if (cnt_after != npix_q) err_d = 1'b1;
                    c_pix_d   = '0;
                    ch_done_d = 1'b1;
                    if (last_ch) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        c_ch_d = c_ch_q + 10'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= IDLE;
            npix_q    <= '0;
            ci_last_q <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
            c_ch_q    <= '0;
            c_pix_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ch_done_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            npix_q    <= npix_d;
            ci_last_q <= ci_last_d;
            bias_q    <= bias_d;
            relu_q    <= relu_d;
            c_ch_q    <= c_ch_d;
            c_pix_q   <= c_pix_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ch_done_q <= ch_done_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge i_clk) begin
        if (pix_acc && !last_ch) acc_q[c_pix_q] <= acc_wr;
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_ch_done = ch_done_q;
    assign o_done    = done_q;
    assign o_busy    = (state_q == ACCUM);
    assign o_err     = err_q;
endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: hand-computed vectors checked one cycle after each step.
module tb_psum_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  mw = '0, mh = '0;
    logic [9:0]  mci = '0;
    logic [15:0] bias = '0;
    logic        relu = 1'b0;
    logic [15:0] d = '0;
    logic        vld = 1'b0, chd = 1'b0;
    logic [15:0] o_data;
    logic        o_valid, o_ch_done, o_done, o_busy, o_err;

    int errs = 0;
    int checks = 0;

    psum_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(32), .MAX_PIX(16), .PIX_AW(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_max_width(mw), .i_max_height(mh), .i_max_ci(mci),
        .i_bias(bias), .i_relu(relu), .i_d(d), .i_valid(vld), .i_ch_done(chd),
        .o_data(o_data), .o_valid(o_valid), .o_ch_done(o_ch_done),
        .o_done(o_done), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h, input int ci, input int b, input bit r);
        start = 1'b1;
        mw = 9'(w); mh = 9'(h); mci = 10'(ci); bias = 16'(b); relu = r;
        cyc();
        start = 1'b0;
        chk("busy_after_start", int'(o_busy), 1);
    endtask

    // One cycle of input; outputs observed afterwards belong to this step.
    task automatic push(input int val, input bit v, input bit done);
        d = 16'(val); vld = v; chd = done;
        cyc();
        vld = 1'b0; chd = 1'b0;
    endtask

    task automatic chk_out(input string tag, input int exp);
        chk({tag, "_valid"}, int'(o_valid), 1);
        chk({tag, "_data"}, int'($signed(o_data)), exp);
    endtask

    initial begin
        int t1 [4] = '{1, -2, 3, 4};
        #2;
        chk("rst_data", int'(o_data), 0);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_chdone", int'(o_ch_done), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_err", int'(o_err), 0);
        cyc();
        rst = 1'b1;
        cyc();

        // ci=1 passthrough
        do_start(2, 2, 1, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push(t1[i], 1'b1, 1'b0);
            chk_out("t1_pix", t1[i]);
        end
        push(0, 1'b0, 1'b1);
        chk("t1_chdone", int'(o_ch_done), 1);
        chk("t1_done", int'(o_done), 1);
        chk("t1_busy", int'(o_busy), 0);
        chk("t1_err", int'(o_err), 0);
        cyc();
        chk("t1_done_pulse", int'(o_done), 0);

        // ci=3, bias=-50: 3*100-50 = 250
        do_start(2, 2, 3, -50, 1'b0);
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 4; i++) begin
                push(100, 1'b1, 1'b0);
                chk("t2_mid_novalid", int'(o_valid), 0);
            end
            push(0, 1'b0, 1'b1);
            chk("t2_mid_chdone", int'(o_ch_done), 1);
            chk("t2_mid_nodone", int'(o_done), 0);
            chk("t2_mid_busy", int'(o_busy), 1);
        end
        for (int i = 0; i < 4; i++) begin
            push(100, 1'b1, 1'b0);
            chk_out("t2_pix", 250);
        end
        push(0, 1'b0, 1'b1);
        chk("t2_chdone", int'(o_ch_done), 1);
        chk("t2_done", int'(o_done), 1);
        chk("t2_err", int'(o_err), 0);

        // Saturation and ReLU on a 1x1 map with ci=2
        do_start(1, 1, 2, 0, 1'b0);
        push(30000, 1'b1, 1'b0); push(0, 1'b0, 1'b1);
        push(30000, 1'b1, 1'b0);
        chk_out("t3_satpos", 32767);
        push(0, 1'b0, 1'b1);
        do_start(1, 1, 2, 0, 1'b1);
        push(-30000, 1'b1, 1'b0); push(0, 1'b0, 1'b1);
        push(-30000, 1'b1, 1'b0);
        chk_out("t3_relu", 0);
        push(0, 1'b0, 1'b1);
        do_start(1, 1, 2, 0, 1'b0);
        push(-30000, 1'b1, 1'b0); push(0, 1'b0, 1'b1);
        push(-30000, 1'b1, 1'b0);
        chk_out("t3_satneg", -32768);
        push(0, 1'b0, 1'b1);
        chk("t3_err", int'(o_err), 0);

        // Pixel count errors
        do_start(2, 2, 1, 0, 1'b0);
        for (int i = 0; i < 3; i++) push(i, 1'b1, 1'b0);
        chk("t4_err_before_done", int'(o_err), 0);
        push(0, 1'b0, 1'b1);
        chk("t4_short_err", int'(o_err), 1);
        chk("t4_short_done", int'(o_done), 1);
        cyc();
        chk("t4_err_sticky", int'(o_err), 1);
        do_start(2, 2, 1, 0, 1'b0);
        chk("t4_err_cleared", int'(o_err), 0);
        for (int i = 0; i < 4; i++) push(i, 1'b1, 1'b0);
        chk("t4_err_at4", int'(o_err), 0);
        push(9, 1'b1, 1'b0);
        chk("t4_5th_dropped", int'(o_valid), 0);
        chk("t4_5th_err", int'(o_err), 1);
        push(0, 1'b0, 1'b1);
        chk("t4_5th_done", int'(o_done), 1);

        // Back-to-back with done coincident on the final pixel
        do_start(2, 2, 2, 0, 1'b0);
        push(10, 1'b1, 1'b0); push(20, 1'b1, 1'b0); push(30, 1'b1, 1'b0); push(40, 1'b1, 1'b1);
        chk("t5_p0_chdone", int'(o_ch_done), 1);
        chk("t5_p0_err", int'(o_err), 0);
        push(1, 1'b1, 1'b0); chk_out("t5_px0", 11);
        push(2, 1'b1, 1'b0); chk_out("t5_px1", 22);
        push(3, 1'b1, 1'b0); chk_out("t5_px2", 33);
        push(4, 1'b1, 1'b1); chk_out("t5_px3", 44);
        chk("t5_done", int'(o_done), 1);
        chk("t5_busy", int'(o_busy), 0);
        chk("t5_err", int'(o_err), 0);

        // Asynchronous reset mid-ACCUM, then a clean restart
        do_start(2, 2, 2, 0, 1'b0);
        push(5, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_data", int'(o_data), 0);
        chk("t6_rst_busy", int'(o_busy), 0);
        chk("t6_rst_valid", int'(o_valid), 0);
        chk("t6_rst_err", int'(o_err), 0);
        cyc();
        rst = 1'b1;
        cyc();
        do_start(1, 1, 1, 0, 1'b0);
        push(7, 1'b1, 1'b0);
        chk_out("t6_pix", 7);
        push(0, 1'b0, 1'b1);
        chk("t6_done", int'(o_done), 1);
        chk("t6_err", int'(o_err), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
